// File: rtl/text_cursor_ctrl_if.sv
// Typer-side strobes, RAM write port and cursor status of the text cursor controller.
// master = typer/driver side, slave = controller side.
interface text_cursor_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic [6:0]        ascii_in;
  logic              write_en;
  logic              ctrl_en;
  logic              ready;
  logic              cmd_drop;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [6:0]        ram_wdata;
  logic [3:0]        cur_col;
  logic [2:0]        cur_row;

  modport master (
    output ascii_in, write_en, ctrl_en,
    input  ready, cmd_drop, ram_we, ram_addr, ram_wdata, cur_col, cur_row
  );

  modport slave (
    input  ascii_in, write_en, ctrl_en,
    output ready, cmd_drop, ram_we, ram_addr, ram_wdata, cur_col, cur_row
  );
endinterface

// File: rtl/text_cursor_ctrl.sv
// Turns typer strobes into text RAM writes and tracks the cursor on a GRID_COL x GRID_ROW grid.
//   state    | meaning
//   ST_IDLE  | ready=1; printable writes, backspace and newline complete here in one cycle
//   ST_CLEAR | ready=0; sweeps every cell with 0x20, then homes the cursor
module text_cursor_ctrl #(
  parameter int GRID_COL   = 10,
  parameter int GRID_ROW   = 5,
  parameter int ADDR_W     = 6,
  parameter int CLR_ON_RST = 1
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  text_cursor_ctrl_if.slave bus
);

  localparam int         CELLS    = GRID_COL * GRID_ROW;
  localparam int         CNT_W    = ADDR_W + 1;
  localparam logic [3:0] LAST_COL = 4'(GRID_COL - 1);
  localparam logic [2:0] LAST_ROW = 3'(GRID_ROW - 1);
  localparam logic [6:0] SPACE    = 7'h20;
  localparam logic [6:0] CODE_BS  = 7'h08;
  localparam logic [6:0] CODE_NL  = 7'h0D;
  localparam logic [6:0] CODE_FF  = 7'h0C;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  localparam state_t ST_RST  = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic   RDY_RST = (CLR_ON_RST == 0);

  state_t            state, state_nxt;
  logic [3:0]        col, col_nxt;
  logic [2:0]        row, row_nxt;
  logic              we, we_nxt;
  logic              drop, drop_nxt;
  logic              rdy;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [6:0]        wdata, wdata_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              printable;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] c, input logic [2:0] r);
    return ADDR_W'(r) * ADDR_W'(GRID_COL) + ADDR_W'(c);
  endfunction

  assign printable = (bus.ascii_in >= 7'h20) && (bus.ascii_in <= 7'h7E);

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) state <= ST_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    we_nxt    = 1'b0;
    drop_nxt  = 1'b0;
    addr_nxt  = addr;
    wdata_nxt = wdata;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (bus.ctrl_en) begin
          case (bus.ascii_in)
            CODE_BS: begin
              if (col != 4'd0) begin
                col_nxt = col - 4'd1;
              end else if (row != 3'd0) begin
                col_nxt = LAST_COL;
                row_nxt = row - 3'd1;
              end
              we_nxt    = 1'b1;
              addr_nxt  = cell_addr(col_nxt, row_nxt);
              wdata_nxt = SPACE;
            end
            CODE_NL: begin
              col_nxt = 4'd0;
              row_nxt = (row == LAST_ROW) ? 3'd0 : row + 3'd1;
            end
            CODE_FF: begin
              state_nxt = ST_CLEAR;
              cnt_nxt   = '0;
            end
            default: ;
          endcase
        end else if (bus.write_en && printable) begin
          we_nxt    = 1'b1;
          addr_nxt  = cell_addr(col, row);
          wdata_nxt = bus.ascii_in;
          if (col != LAST_COL) begin
            col_nxt = col + 4'd1;
          end else begin
            col_nxt = 4'd0;
            row_nxt = (row == LAST_ROW) ? 3'd0 : row + 3'd1;
          end
        end
      end
      ST_CLEAR: begin
        drop_nxt = bus.write_en | bus.ctrl_en;
        if (cnt < CNT_W'(CELLS)) begin
          we_nxt    = 1'b1;
          addr_nxt  = cnt[ADDR_W-1:0];
          wdata_nxt = SPACE;
          cnt_nxt   = cnt + 1'b1;
        end else begin
          col_nxt   = 4'd0;
          row_nxt   = 3'd0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_RST;
    endcase
  end

  // All outputs are registered copies of the next-state decode above.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      row   <= '0;
      we    <= 1'b0;
      drop  <= 1'b0;
      rdy   <= RDY_RST;
      addr  <= '0;
      wdata <= '0;
      cnt   <= '0;
    end else begin
      col   <= col_nxt;
      row   <= row_nxt;
      we    <= we_nxt;
      drop  <= drop_nxt;
      rdy   <= (state_nxt == ST_IDLE);
      addr  <= addr_nxt;
      wdata <= wdata_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign bus.ready     = rdy;
  assign bus.cmd_drop  = drop;
  assign bus.ram_we    = we;
  assign bus.ram_addr  = addr;
  assign bus.ram_wdata = wdata;
  assign bus.cur_col   = col;
  assign bus.cur_row   = row;

endmodule
